// File: rtl/ram_arb_pkg.sv
// Shared opcodes and FSM state type for the command-RAM arbiter.
package ram_arb_pkg;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side transaction bus plus the RAM command/response bus.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 8
);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_wr;
  logic [2*ADDR_SIZE-1:0] req_addr;
  logic [2*ADDR_SIZE-1:0] req_wdata;
  logic [1:0]             rsp_valid;
  logic [ADDR_SIZE-1:0]   rsp_data;
  logic                   rsp_err;
  logic                   busy;
  logic [ADDR_SIZE+1:0]   ram_din;
  logic                   ram_rx_valid;
  logic [ADDR_SIZE-1:0]   ram_dout;
  logic                   ram_tx_valid;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy, ram_din, ram_rx_valid
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy, ram_din, ram_rx_valid
  );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin grant; the requester not granted last has priority.
module ram_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid_i,
  input  logic       idle_i,
  output logic [1:0] req_ready_o,
  output logic       gnt_id_o,
  output logic       hs_o
);

  logic last_grant_q;
  logic pref;
  logic gnt_any;

  always_comb begin
    pref        = ~last_grant_q;
    gnt_id_o    = pref;
    gnt_any     = 1'b0;
    req_ready_o = 2'b00;
    if (req_valid_i[pref]) begin
      gnt_id_o = pref;
      gnt_any  = 1'b1;
    end else if (req_valid_i[~pref]) begin
      gnt_id_o = ~pref;
      gnt_any  = 1'b1;
    end
    if (idle_i && gnt_any) req_ready_o[gnt_id_o] = 1'b1;
    hs_o = idle_i && gnt_any;
  end

  // Reset to 1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant_q <= 1'b1;
    else if (hs_o) last_grant_q <= gnt_id_o;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises requester read/write transactions into the RAM's two-word
// command protocol and returns read data (or a timeout error) to the owner.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e               state_q;
  logic                 id_q;
  logic                 wr_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ADDR_SIZE+1:0] din_q;
  logic                 rxv_q;
  logic [1:0]           rspv_q;
  logic [ADDR_SIZE-1:0] rspd_q;
  logic                 rspe_q;

  logic                 gnt_id;
  logic                 hs;
  logic                 gnt_wr;
  logic [ADDR_SIZE-1:0] gnt_addr;
  logic [ADDR_SIZE-1:0] gnt_wdata;

  ram_arb_rr u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (bus.req_valid),
    .idle_i      (state_q == ST_IDLE),
    .req_ready_o (bus.req_ready),
    .gnt_id_o    (gnt_id),
    .hs_o        (hs)
  );

  assign gnt_wr    = bus.req_wr[gnt_id];
  assign gnt_addr  = gnt_id ? bus.req_addr[2*ADDR_SIZE-1:ADDR_SIZE]
                            : bus.req_addr[ADDR_SIZE-1:0];
  assign gnt_wdata = gnt_id ? bus.req_wdata[2*ADDR_SIZE-1:ADDR_SIZE]
                            : bus.req_wdata[ADDR_SIZE-1:0];

  // Outputs are loaded on the transition into a state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      rxv_q   <= 1'b0;
      rspv_q  <= 2'b00;
      rspd_q  <= '0;
      rspe_q  <= 1'b0;
    end else begin
      rspv_q <= 2'b00;
      rspe_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          rxv_q <= 1'b0;
          if (hs) begin
            id_q    <= gnt_id;
            wr_q    <= gnt_wr;
            addr_q  <= gnt_addr;
            wdata_q <= gnt_wdata;
            din_q   <= {gnt_wr ? OP_WADDR : OP_RADDR, gnt_addr};
            rxv_q   <= 1'b1;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          din_q   <= wr_q ? {OP_WDATA, wdata_q} : {OP_RDATA, ADDR_SIZE'(0)};
          rxv_q   <= 1'b1;
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          rxv_q <= 1'b0;
          cnt_q <= '0;
          if (wr_q) begin
            rspv_q[id_q] <= 1'b1;
            rspd_q       <= '0;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          rxv_q <= 1'b0;
          if (bus.ram_tx_valid) begin
            rspv_q[id_q] <= 1'b1;
            rspd_q       <= bus.ram_dout;
            state_q      <= ST_IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rspv_q[id_q] <= 1'b1;
            rspd_q       <= '0;
            rspe_q       <= 1'b1;
            state_q      <= ST_IDLE;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.ram_din      = din_q;
  assign bus.ram_rx_valid = rxv_q;
  assign bus.rsp_valid    = rspv_q;
  assign bus.rsp_data     = rspd_q;
  assign bus.rsp_err      = rspe_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench: drivers queue expected RAM commands and responses with
// their due cycle; a negedge monitor pops and compares whatever the DUT emits.
module tb_ram_arbiter;

  localparam int unsigned AS = 8;
  localparam int unsigned TO = 4;

  typedef struct { int cyc; logic [AS+1:0] din; } cmd_t;
  typedef struct { int cyc; logic [1:0] v; logic [AS-1:0] d; logic e; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic          v   [2];
  logic          wrv [2];
  logic [AS-1:0] av  [2];
  logic [AS-1:0] wv  [2];
  logic          ram_en;
  logic          ram_tx;
  logic [AS-1:0] ram_dout_r;
  logic [AS-1:0] ram_addr;
  logic [AS-1:0] mem [256];

  cmd_t cmdq[$];
  rsp_t rspq[$];
  int   glog[$];
  cmd_t mc;
  rsp_t mr;

  ram_arbiter_if #(.ADDR_SIZE(AS)) bus ();

  ram_arbiter #(.ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req_valid    = {v[1], v[0]};
  assign bus.req_wr       = {wrv[1], wrv[0]};
  assign bus.req_addr     = {av[1], av[0]};
  assign bus.req_wdata    = {wv[1], wv[0]};
  assign bus.ram_dout     = ram_dout_r;
  assign bus.ram_tx_valid = ram_tx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: latches address words, stores write data, answers 11 next cycle.
  always @(posedge clk) begin
    ram_tx <= 1'b0;
    if (bus.ram_rx_valid) begin
      case (bus.ram_din[AS+1:AS])
        2'b00, 2'b10: ram_addr <= bus.ram_din[AS-1:0];
        2'b01:        mem[ram_addr] <= bus.ram_din[AS-1:0];
        default: if (ram_en) begin
          ram_tx     <= 1'b1;
          ram_dout_r <= mem[ram_addr];
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (bus.ram_rx_valid) begin
      n_cmp++;
      if (cmdq.size() == 0) begin
        n_bad++;
        $display("FAIL cmd: got din %03h at cycle %0d, expected none", bus.ram_din, cyc);
      end else begin
        mc = cmdq.pop_front();
        if (bus.ram_din !== mc.din || cyc != mc.cyc) begin
          n_bad++;
          $display("FAIL cmd: got din %03h at cycle %0d, expected %03h at cycle %0d",
                   bus.ram_din, cyc, mc.din, mc.cyc);
        end
      end
    end
    if (bus.rsp_valid != 2'b00) begin
      n_cmp++;
      if (rspq.size() == 0) begin
        n_bad++;
        $display("FAIL rsp: got valid %b data %02h err %b at cycle %0d, expected none",
                 bus.rsp_valid, bus.rsp_data, bus.rsp_err, cyc);
      end else begin
        mr = rspq.pop_front();
        if (bus.rsp_valid !== mr.v || bus.rsp_data !== mr.d ||
            bus.rsp_err !== mr.e || cyc != mr.cyc) begin
          n_bad++;
          $display("FAIL rsp: got valid %b data %02h err %b cycle %0d, expected %b %02h %b cycle %0d",
                   bus.rsp_valid, bus.rsp_data, bus.rsp_err, cyc, mr.v, mr.d, mr.e, mr.cyc);
        end
      end
    end
    if (bus.busy) begin
      n_cmp++;
      if (bus.req_ready !== 2'b00) begin
        n_bad++;
        $display("FAIL ready_while_busy: got %b at cycle %0d, expected 00", bus.req_ready, cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One transaction from requester id; caller starts it just after a posedge.
  task automatic do_req(input int id, input logic wr, input logic [AS-1:0] addr,
                        input logic [AS-1:0] wd, input logic [AS-1:0] ed,
                        input logic ee, output int t);
    cmd_t c;
    rsp_t r;
    logic got;
    got = 1'b0;
    t   = -1;
    v[id] = 1'b1; wrv[id] = wr; av[id] = addr; wv[id] = wd;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = bus.req_ready[id];
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout: requester %0d got no ready, expected one", id);
      v[id] = 1'b0;
      return;
    end
    t = cyc;
    c.cyc = t + 1; c.din = {wr ? 2'b00 : 2'b10, addr}; cmdq.push_back(c);
    c.cyc = t + 2; c.din = wr ? {2'b01, wd} : {2'b11, 8'h00}; cmdq.push_back(c);
    r.cyc = wr ? t + 3 : (ee ? t + 3 + TO : t + 4);
    r.v   = (id == 0) ? 2'b01 : 2'b10;
    r.d   = ed;
    r.e   = ee;
    rspq.push_back(r);
    glog.push_back(id);
    @(posedge clk);
    #1 v[id] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (cmdq.size() != 0 || rspq.size() != 0); i++) @(negedge clk);
    if (cmdq.size() != 0 || rspq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d cmds %0d rsps outstanding, expected 0", cmdq.size(), rspq.size());
      cmdq.delete();
      rspq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tt, tp, rc;
    logic got;
    cmd_t c;
    logic [AS-1:0] wdat [4];
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    v[0] = 1'b0; v[1] = 1'b0; wrv[0] = 1'b0; wrv[1] = 1'b0;
    av[0] = '0; av[1] = '0; wv[0] = '0; wv[1] = '0;
    ram_en = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_din", 32'(bus.ram_din), 32'h0);
    chk("reset_rxv", 32'(bus.ram_rx_valid), 32'h0);
    chk("reset_rspv", 32'(bus.rsp_valid), 32'h0);
    chk("reset_rspd", 32'(bus.rsp_data), 32'h0);
    chk("reset_rspe", 32'(bus.rsp_err), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // write then read-back through the other requester
    do_req(0, 1'b1, 8'h12, 8'hA5, 8'h00, 1'b0, t0);
    drain();
    do_req(1, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, t0);
    drain();

    // both requesters contending: strict alternation starting with 0
    glog.delete();
    fork
      begin
        do_req(0, 1'b1, 8'h20, 8'h5A, 8'h00, 1'b0, t0);
        do_req(0, 1'b1, 8'h21, 8'h5B, 8'h00, 1'b0, t0);
      end
      begin
        do_req(1, 1'b1, 8'h30, 8'hC3, 8'h00, 1'b0, t1);
        do_req(1, 1'b1, 8'h31, 8'hC4, 8'h00, 1'b0, t1);
      end
    join
    drain();
    chk("rr_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(i % 2));

    // read timeout, with requester 1 queued behind it
    ram_en = 1'b0;
    fork
      do_req(0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, t0);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_req(1, 1'b1, 8'h41, 8'h77, 8'h00, 1'b0, t1);
      end
    join
    chk("timeout_next_accept", 32'(t1 - t0), 32'd7);
    drain();
    ram_en = 1'b1;

    // reset while the DATA word is on the bus
    got = 1'b0;
    v[0] = 1'b1; wrv[0] = 1'b1; av[0] = 8'h55; wv[0] = 8'h66;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = bus.req_ready[0];
    end
    chk("rst_test_hs", 32'(got), 32'h1);
    t0 = cyc;
    c.cyc = t0 + 1; c.din = 10'h055; cmdq.push_back(c);
    c.cyc = t0 + 2; c.din = 10'h166; cmdq.push_back(c);
    @(posedge clk);
    #1 v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_rxv_drop", 32'(bus.ram_rx_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_rspv", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    chk("rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    rc = cyc;
    glog.delete();
    fork
      do_req(0, 1'b1, 8'h60, 8'h01, 8'h00, 1'b0, t0);
      do_req(1, 1'b1, 8'h61, 8'h02, 8'h00, 1'b0, t1);
    join
    chk("post_rst_accept", 32'(t0 - rc), 32'd0);
    chk("post_rst_first", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);
    chk("post_rst_second", 32'(t1 - rc), 32'd3);
    drain();

    // back-to-back writes from requester 0, then reads in order
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b1, AS'(i), wdat[i], 8'h00, 1'b0, tt);
      if (i > 0) chk("wr_spacing", 32'(tt - tp), 32'd3);
      tp = tt;
    end
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, AS'(i), 8'h00, wdat[i], 1'b0, tt);
      if (i > 0) chk("rd_spacing", 32'(tt - tp), 32'd4);
      tp = tt;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin front end for the single-port command RAM. Each requester issues complete read or write transactions (address plus data). The block serialises each transaction into the RAM's two-word command protocol over `din`/`rx_valid`: opcodes 00 write-addr, 01 write-data, 10 read-addr, 11 read-data. It collects the read result from `dout`/`tx_valid`, with a timeout, and returns it to the owning requester.

## Interface
- `ADDR_SIZE`, 8: RAM address and data width.
- `TIMEOUT`, 4: max cycles in WAIT for `ram_tx_valid`; must be ≥1.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester transaction request; bit i = requester i.
- `req_ready`  out  2  per-requester accept, combinational.
- `req_wr`  in  2  1 = write, 0 = read.
- `req_addr`  in  2*ADDR_SIZE  requester i at `[i*ADDR_SIZE +: ADDR_SIZE]`.
- `req_wdata`  in  2*ADDR_SIZE  same packing; ignored for reads.
- `rsp_valid`  out  2  one-cycle completion pulse, one-hot to the owning requester.
- `rsp_data`  out  ADDR_SIZE  read data; 0 for writes and errors.
- `rsp_err`  out  1  read timed out; qualified by `rsp_valid`.
- `busy`  out  1  state ≠ IDLE.
- `ram_din`  out  ADDR_SIZE+2  `{opcode[1:0], payload}` to the RAM.
- `ram_rx_valid`  out  1  command strobe to the RAM.
- `ram_dout`  in  ADDR_SIZE  RAM read data.
- `ram_tx_valid`  in  1  RAM read-data valid.

## Operation
- FSM states: IDLE, ADDR, DATA, WAIT.
- IDLE: the arbiter picks one requester among those with `req_valid`. `req_ready` is high only for that requester, only in IDLE. A handshake latches id, wr, addr and wdata, and moves to ADDR.
- ADDR: `ram_rx_valid`=1; `ram_din` = {00,addr} for a write, {10,addr} for a read. Next state is DATA.
- DATA: `ram_rx_valid`=1; `ram_din` = {01,wdata} for a write, {11,0} for a read.
  - Write: next state IDLE; `rsp_valid[id]` pulses next cycle.
  - Read: next state WAIT; timeout counter cleared.
- WAIT: `ram_rx_valid`=0.
  - If `ram_tx_valid`: latch `ram_dout` into `rsp_data`, pulse `rsp_valid[id]` with `rsp_err`=0, go to IDLE.
  - Otherwise the counter increments. On the TIMEOUT-th WAIT cycle without `ram_tx_valid`: pulse `rsp_valid[id]` with `rsp_err`=1 and `rsp_data`=0, go to IDLE.
- Round robin: priority goes to the requester other than `last_grant`. `last_grant` updates on each handshake. Reset value of `last_grant` is 1, so requester 0 wins first.
- When neither requester is valid, IDLE holds and `ram_rx_valid`=0.
- Timeout counter width is $clog2(TIMEOUT+1); it saturates, never wraps.

## Timing
- Registered outputs: `ram_din`, `ram_rx_valid`, `rsp_valid`, `rsp_data`, `rsp_err`. Combinational outputs: `req_ready`, `busy`.
- Reset values: state IDLE; `ram_din`=0, `ram_rx_valid`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `req_ready`=0, `last_grant`=1, counter 0.
- Handshake in cycle T.
  - Cycle T+1: ADDR word on the RAM bus.
  - Cycle T+2: DATA word on the RAM bus.
  - Write: `rsp_valid` in T+3, which is also an IDLE cycle that may accept.
  - Read: `ram_tx_valid` is expected in T+3 (WAIT); `rsp_valid` in T+4, and T+4 is IDLE.
  - Read timeout: response in T+3+TIMEOUT.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- `ram_tx_valid` seen during ADDR or DATA is ignored. The RAM clears it on any non-11 command.
- Reset mid-transaction: the transaction is dropped and no response is produced. `ram_rx_valid` drops immediately (asynchronous). The first cycle after reset deasserts is IDLE and may accept.

## Structure
- `ram_arb_pkg`: opcode localparams (`OP_WADDR`, `OP_WDATA`, `OP_RADDR`, `OP_RDATA`) and the state enum.
- Sub-module `ram_arb_rr`: 2-way round-robin grant logic, containing `last_grant`, fed by the handshake strobe.

## Test plan
All values with ADDR_SIZE=8, TIMEOUT=4.
- Req0 writes addr 0x12, data 0xA5 → `ram_din` 0x012 at T+1 and 0x1A5 at T+2; `rsp_valid`=01 at T+3.
- Req1 then reads 0x12 → `ram_din` 0x212 then 0x300; `rsp_valid`=10 with `rsp_data`=0xA5 at T+4.
- Both requesters valid continuously from reset → grants 0,1,0,1…; neither `req_ready` is high while busy.
- RAM model never asserts `tx_valid` → read returns `rsp_err`=1, `rsp_data`=0 at T+7; the next request is accepted at T+7.
- `rst` pulsed while in DATA → `ram_rx_valid`=0 at once, no `rsp_valid`, `busy`=0. A new request is accepted in the first cycle after release, with requester 0 preferred.
- Back-to-back writes from req0 only → `req_ready[0]` high every 3rd cycle. Four writes to 0x00–0x03 followed by four reads return the written data in order.
